bin2therm_dwa: RTL

//  Registered, parametrised binary-to-unary converter for unit-element DAC / neuron drive.
//  Two modes:
//   - Plain thermometer: fill from LSB.
//   - Data-weighted averaging (DWA): the filled window rotates over the element array,

---
 rtl/b2t_pkg.sv | 18 +
 rtl/therm_rotl.sv | 20 ++
 rtl/bin2therm_dwa.sv | 91 +++++++++
 3 files changed

// File: rtl/b2t_pkg.sv
// Shared types and helpers for the binary-to-unary converter.
// The mode enum, the default sizes and the code clamp are defined here.
package b2t_pkg;

    typedef enum logic {
        B2T_THERM = 1'b0,
        B2T_DWA   = 1'b1
    } b2t_mode_e;

    localparam int B2T_BIN_W  = 5;
    localparam int B2T_N_ELEM = 31;

    function automatic int unsigned clamp_code(input int unsigned code,
                                               input int unsigned n_elem);
        return (code > n_elem) ? n_elem : code;
    endfunction

endpackage

// File: rtl/therm_rotl.sv
// Combinational rotate-left of an N_ELEM-bit word.
// The rotate amount must already be below N_ELEM; the DWA pointer never leaves that range.
module therm_rotl #(
    parameter int N_ELEM = 31,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic [N_ELEM-1:0] din,
    input  logic [PTR_W-1:0]  rot,
    output logic [N_ELEM-1:0] dout
);

    logic [2*N_ELEM-1:0] doubled;

    // The upper half of the shifted doubled word is the word rotated left by rot.
    always_comb begin
        doubled = {din, din} << rot;
        dout    = doubled[2*N_ELEM-1:N_ELEM];
    end

endmodule

// File: rtl/bin2therm_dwa.sv
// Registered binary-to-unary converter with plain thermometer and
// data-weighted-averaging modes for driving a unit-element array.
module bin2therm_dwa
    import b2t_pkg::*;
#(
    parameter int BIN_W  = B2T_BIN_W,
    parameter int N_ELEM = B2T_N_ELEM,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BIN_W-1:0]  in,
    input  logic              mode,
    input  logic              ptr_clr,
    output logic              out_valid,
    output logic [N_ELEM-1:0] out,
    output logic [PTR_W-1:0]  ptr
);

    localparam int CNT_W = PTR_W + 1;

    b2t_mode_e         mode_e;
    logic [CNT_W-1:0]  code_c;
    logic [N_ELEM-1:0] therm_mask;
    logic [N_ELEM-1:0] rot_mask;
    logic [PTR_W-1:0]  start_p;
    logic [CNT_W-1:0]  sum;
    logic [CNT_W-1:0]  sum_wrap;
    logic [PTR_W-1:0]  ptr_next;

    logic              out_valid_d, out_valid_q;
    logic [N_ELEM-1:0] out_d, out_q;
    logic [PTR_W-1:0]  ptr_d, ptr_q;

    always_comb begin
        mode_e  = b2t_mode_e'(mode);
        code_c  = CNT_W'(clamp_code(32'(in), 32'(N_ELEM)));
        start_p = ptr_clr ? '0 : ptr_q;
        for (int i = 0; i < N_ELEM; i++) begin
            therm_mask[i] = (CNT_W'(i) < code_c);
        end
    end

    therm_rotl #(
        .N_ELEM (N_ELEM),
        .PTR_W  (PTR_W)
    ) u_rotl (
        .din  (therm_mask),
        .rot  (start_p),
        .dout (rot_mask)
    );

    // p + c stays below 2*N_ELEM, so one conditional subtract is a full modulo.
    always_comb begin
        sum      = {1'b0, start_p} + code_c;
        sum_wrap = (sum >= CNT_W'(N_ELEM)) ? (sum - CNT_W'(N_ELEM)) : sum;
        ptr_next = PTR_W'(sum_wrap);
    end

    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        ptr_d       = start_p;
        if (in_valid) begin
            if (mode_e == B2T_DWA) begin
                out_d = rot_mask;
                ptr_d = ptr_next;
            end else begin
                out_d = therm_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ptr       = ptr_q;

endmodule
